// File: rtl/approxexp_seq.sv
// approxexp_seq -- sequencer and result stage for the Horner-method ApproxExp
// loop datapath.
//
// One transaction: accept (z, ccs) in IDLE, pulse y_init for one cycle so the
// loop datapath loads C[0], then hold y_loop for N_TERMS cycles while C_index
// walks 1..N_TERMS. The final y is then scaled by ccs and the result is
// offered on a valid/ready handshake until the consumer takes it.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   operand handshake; in_ready is high only in IDLE
//   z_in, ccs_in        unsigned Q63 operands
//   out_valid/out_ready result handshake
//   result              (y_final * ccs) >> 63, truncated to W bits
//   busy                high in any state other than IDLE
//   y_init, y_loop      loop datapath controls (never both high)
//   C_index             coefficient index, 0 outside LOOP
//   z_i                 registered z, stable for the whole transaction
//   y_o                 current y from the loop datapath
module approxexp_seq #(
    parameter int W       = 64,
    parameter int N_TERMS = 12,
    parameter int IDX_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     z_in,
    input  logic [W-1:0]     ccs_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     result,
    output logic             busy,
    output logic             y_init,
    output logic             y_loop,
    output logic [IDX_W-1:0] C_index,
    output logic [W-1:0]     z_i,
    input  logic [W-1:0]     y_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_LOOP,
        ST_SCALE,
        ST_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TERMS);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] c_index_q, c_index_d;
    logic [W-1:0]     z_q, z_d;
    logic [W-1:0]     ccs_q, ccs_d;
    logic [W-1:0]     result_q, result_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             y_init_q, y_init_d;
    logic             y_loop_q, y_loop_d;
    logic [2*W-1:0]   product;

    always_comb begin
        state_d     = state_q;
        c_index_d   = c_index_q;
        z_d         = z_q;
        ccs_d       = ccs_q;
        result_d    = result_q;
        // Full-width unsigned product; the Q63 result is bits [2W-2:W-1].
        product     = {{W{1'b0}}, y_o} * {{W{1'b0}}, ccs_q};

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    z_d     = z_in;
                    ccs_d   = ccs_in;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                state_d   = ST_LOOP;
                c_index_d = ONE_IDX;
            end
            ST_LOOP: begin
                if (c_index_q == LAST_IDX) begin
                    state_d   = ST_SCALE;
                    c_index_d = '0;
                end else begin
                    c_index_d = c_index_q + ONE_IDX;
                end
            end
            ST_SCALE: begin
                // The last Horner step landed at the previous edge, so y_o is final here.
                result_d = W'(product >> (W - 1));
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                c_index_d = '0;
            end
        endcase

        // Control outputs are registered and follow the state being entered.
        y_init_d    = (state_d == ST_INIT);
        y_loop_d    = (state_d == ST_LOOP);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            c_index_q   <= '0;
            z_q         <= '0;
            ccs_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            y_init_q    <= 1'b0;
            y_loop_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            c_index_q   <= c_index_d;
            z_q         <= z_d;
            ccs_q       <= ccs_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            y_init_q    <= y_init_d;
            y_loop_q    <= y_loop_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = busy_q;
    assign y_init    = y_init_q;
    assign y_loop    = y_loop_q;
    assign C_index   = c_index_q;
    assign z_i       = z_q;

endmodule

// File: tb/tb_approxexp_seq.sv
// Bench for approxexp_seq: models the peer loop datapath, predicts every
// output from the transaction timeline, and checks literal results.
module tb_approxexp_seq;

    localparam logic [63:0] COEF [13] = '{
        64'h00000004741183A3, 64'h00000036548CFC06, 64'h0000024FDCBF140A,
        64'h0000171D939DE045, 64'h0000D00CF58F6F84, 64'h000680681CF796E3,
        64'h002D82D8305B0FEA, 64'h011111110E066FD0, 64'h0555555555070F00,
        64'h155555555581FF00, 64'h400000000002B400, 64'h7FFFFFFFFFFF4800,
        64'h8000000000000000
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] z_in = '0;
    logic [63:0] ccs_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;
    logic        busy;
    logic        y_init;
    logic        y_loop;
    logic [3:0]  C_index;
    logic [63:0] z_i;
    logic [63:0] y_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    approxexp_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .z_in(z_in), .ccs_in(ccs_in), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy), .y_init(y_init), .y_loop(y_loop),
        .C_index(C_index), .z_i(z_i), .y_o(y_o)
    );

    // Peer loop datapath: y <= C[0] on init, y <= C[i] - (z*y)>>63 per step.
    logic [63:0] y_peer = '0;
    always @(posedge clk) begin
        logic [127:0] p;
        p = {64'd0, z_i} * {64'd0, y_peer};
        if (y_init)      y_peer <= COEF[0];
        else if (y_loop) y_peer <= COEF[C_index] - p[126:63];
    end
    assign y_o = y_peer;

    function automatic logic [63:0] ref_exp(input logic [63:0] z, input logic [63:0] c);
        logic [63:0]  y;
        logic [127:0] p;
        y = COEF[0];
        for (int u = 1; u <= 12; u++) begin
            p = {64'd0, z} * {64'd0, y};
            y = COEF[u] - p[126:63];
        end
        p = {64'd0, y} * {64'd0, c};
        return p[126:63];
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Timeline model: age counts cycles since accept (0 = idle, 15 = result offered).
    int          cyc = 0;
    int          age = 0;
    int          acc_cyc = 0;
    logic [63:0] exp_pending = '0;
    logic [63:0] exp_res = '0;
    logic [63:0] exp_zi = '0;
    logic        chk_en = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            age     <= 0;
            exp_res <= '0;
            exp_zi  <= '0;
        end else if (age == 0) begin
            if (in_valid) begin
                age         <= 1;
                acc_cyc     <= cyc;
                exp_zi      <= z_in;
                exp_pending <= ref_exp(z_in, ccs_in);
                $display("accept z=%h ccs=%h at cycle %0d", z_in, ccs_in, cyc);
            end
        end else if (age < 15) begin
            if (age == 14) exp_res <= exp_pending;
            age <= age + 1;
        end else if (out_ready) begin
            age <= 0;
            $display("deliver result=%h at cycle %0d", result, cyc);
        end
    end

    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", 64'(in_ready), 64'(age == 0));
            check("busy", 64'(busy), 64'(age != 0));
            check("y_init", 64'(y_init), 64'(age == 1));
            check("y_loop", 64'(y_loop), 64'(age >= 2 && age <= 13));
            check("C_index", 64'(C_index), (age >= 2 && age <= 13) ? 64'(age - 1) : 64'd0);
            check("out_valid", 64'(out_valid), 64'(age == 15));
            check("result", result, exp_res);
            check("z_i", z_i, exp_zi);
            if (y_init && y_loop) check("init_loop_excl", 64'd1, 64'd0);
            if (out_valid && !prev_ov) check("latency", 64'(cyc - acc_cyc), 64'd15);
            prev_ov <= out_valid;
        end
    end

    // Starts just after a negedge; returns just after the negedge following the handshake.
    task automatic run_txn(input logic [63:0] z, input logic [63:0] c, input int hold,
                           output logic [63:0] res);
        int n;
        in_valid  = 1'b1;
        z_in      = z;
        ccs_in    = c;
        out_ready = (hold == 0);
        @(negedge clk);
        n = 0;
        while (!out_valid && n < 100) begin
            in_valid = 1'($urandom_range(0, 1));
            z_in     = {$urandom, $urandom};
            ccs_in   = {$urandom, $urandom};
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL out_valid_timeout: got no out_valid expected within 100 cycles");
        end
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            out_ready = 1'b1;
        end
        res = result;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] r;
        logic [63:0] diff;
        int n;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_C_index", 64'(C_index), 64'd0);
        check("rst_z_i", z_i, 64'd0);
        chk_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);

        run_txn(64'd0, 64'h8000000000000000, 0, r);
        check("lit_z0_ccs1", r, 64'h8000000000000000);
        run_txn(64'd0, 64'h4000000000000000, 0, r);
        check("lit_z0_ccs_half", r, 64'h4000000000000000);
        run_txn(64'd0, 64'd0, 0, r);
        check("lit_z0_ccs0", r, 64'd0);

        // exp(-ln2) with unit scale, held off for 20 cycles.
        run_txn(64'h58B90BFBE8E7BCD5, 64'h8000000000000000, 20, r);
        check("lit_ln2_model", r, ref_exp(64'h58B90BFBE8E7BCD5, 64'h8000000000000000));
        diff = (r > 64'h4000000000000000) ? r - 64'h4000000000000000 : 64'h4000000000000000 - r;
        check("lit_ln2_near_half", 64'(diff < 64'h0000010000000000), 64'd1);
        // Back-to-back accept right after the handshake.
        run_txn(64'h1234_5678_9ABC_DEF0, 64'h7FFF_FFFF_FFFF_FFFF, 0, r);
        check("b2b_result", r, ref_exp(64'h1234_5678_9ABC_DEF0, 64'h7FFF_FFFF_FFFF_FFFF));

        // Abort in LOOP at C_index=6.
        in_valid  = 1'b1;
        z_in      = 64'h3333_3333_3333_3333;
        ccs_in    = 64'h8000000000000000;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (C_index != 4'd6 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_idx6", 64'(C_index), 64'd6);
        rst = 1'b1;
        @(negedge clk);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_y_loop", 64'(y_loop), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        run_txn(64'h0F0F_0F0F_0F0F_0F0F, 64'h6000_0000_0000_0001, 0, r);
        check("post_abort_result", r, ref_exp(64'h0F0F_0F0F_0F0F_0F0F, 64'h6000_0000_0000_0001));

        for (int i = 0; i < 20; i++) begin
            logic [63:0] z;
            logic [63:0] c;
            z = {$urandom, $urandom};
            c = {$urandom, $urandom};
            if (i % 4 == 0) z = z >> 1;
            run_txn(z, c, int'($urandom_range(0, 5)), r);
            check("rand_result", r, ref_exp(z, c));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
